anton_neopixel_stream_seq: RTL and testbench

Parametrised successor to the NeoPixel stream controller, running in the clk7mhz domain between the APB register file and the bit-pattern encoder. It owns the full frame sequencer: an IDLE/TRANSMIT/RESET state machine, a sub-bit counter, a pixel-bit counter, a pixel-index counter and a latch-reset timer. Beyond the previous generation it adds:
- runtime RGB/RGBW pixel width (24/32 bits);
- continuous (loop) refresh;
- graceful stop on a pixel boundary;
- frame-start latching of limit settings;
- a frame-done pulse and a frame counter.

---
 rtl/anton_neopixel_stream_seq_pkg.sv | 24 ++
 rtl/anton_neopixel_stream_seq_reset_timer.sv | 33 +++
 rtl/anton_neopixel_stream_seq.sv | 168 ++++++++++++++++
 tb/tb_anton_neopixel_stream_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_stream_seq_pkg.sv
// Shared definitions for the NeoPixel frame sequencer.
//   state_e              : sequencer states, encoded as seen on the 2-bit state port
//   BITS_RGB / BITS_RGBW : bits per pixel for the two pixel formats
//   RESET_CYCLES_DEFAULT : 60us latch period at 7MHz
//   BUFFER_END_DEFAULT   : last byte index of the default pixel buffer
//   last_bit()           : index of the final bit of a pixel for the given format
package anton_neopixel_stream_seq_pkg;

  typedef enum logic [1:0] {
    ENUM_STATE_IDLE     = 2'd0,
    ENUM_STATE_TRANSMIT = 2'd1,
    ENUM_STATE_RESET    = 2'd2
  } state_e;

  localparam int BITS_RGB             = 24;
  localparam int BITS_RGBW            = 32;
  localparam int RESET_CYCLES_DEFAULT = 420;
  localparam int BUFFER_END_DEFAULT   = 255;

  function automatic logic [4:0] last_bit(input logic rgbw);
    return rgbw ? 5'(BITS_RGBW - 1) : 5'(BITS_RGB - 1);
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_seq_reset_timer.sv
// Latch-period timer for the NeoPixel sequencer.
//   clk7mhz : stream clock
//   rstn    : asynchronous active-low reset
//   load    : return the count to 0 (wins over count)
//   count   : advance one step per cycle, wrapping after the final count
//   done    : final count (RESET_CYCLES-1) reached while counting
module anton_neopixel_stream_seq_reset_timer #(
  parameter int RESET_CYCLES = 420
) (
  input  logic clk7mhz,
  input  logic rstn,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int CNT_W = $clog2(RESET_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  assign done = count && (cnt_q == CNT_W'(RESET_CYCLES - 1));

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_seq.sv
// NeoPixel frame sequencer (IDLE -> TRANSMIT -> RESET) in the clk7mhz domain.
// Walks the pixel buffer bit by bit, MSB first, with PATTERN_STEPS sub-bit
// steps per bit, then holds the line low for RESET_CYCLES. Frame limit, pixel
// width and addressing mode are latched at frame start.
//   clk7mhz, rstn          : clock, asynchronous active-low reset
//   reg_ctrl_*             : control bits from the register file (init = soft clear)
//   reg_max                : software pixel limit (low BUFFER_BITS used)
//   state                  : 0 IDLE, 1 TRANSMIT, 2 RESET
//   pixel_index            : current buffer byte index
//   pixel_bit_index        : bit within the pixel, 0 = first sent
//   bit_pattern_index      : sub-bit step
//   stream_output/_reset   : TRANSMIT / RESET active
//   stream_pattern_of      : last sub-bit step of the bit
//   stream_bit_of          : last sub-bit of the last bit of the pixel
//   stream_pixel_of        : current pixel is the last of the frame
//   frame_done             : one-cycle pulse on the final latch-period cycle
//   frame_count            : completed frames, wrapping
module anton_neopixel_stream_seq
  import anton_neopixel_stream_seq_pkg::*;
#(
  parameter  int BUFFER_END     = BUFFER_END_DEFAULT,
  parameter  int PATTERN_STEPS  = 8,
  parameter  int RESET_CYCLES   = RESET_CYCLES_DEFAULT,
  parameter  int FRAME_CNT_BITS = 16,
  localparam int BUFFER_BITS    = $clog2(BUFFER_END + 1),
  localparam int PAT_W          = $clog2(PATTERN_STEPS)
) (
  input  logic                      clk7mhz,
  input  logic                      rstn,
  input  logic                      reg_ctrl_init,
  input  logic                      reg_ctrl_run,
  input  logic                      reg_ctrl_limit,
  input  logic                      reg_ctrl_32bit,
  input  logic                      reg_ctrl_rgbw,
  input  logic                      reg_ctrl_loop,
  input  logic [12:0]               reg_max,
  output logic [1:0]                state,
  output logic [BUFFER_BITS-1:0]    pixel_index,
  output logic [4:0]                pixel_bit_index,
  output logic [PAT_W-1:0]          bit_pattern_index,
  output logic                      stream_output,
  output logic                      stream_reset,
  output logic                      stream_pattern_of,
  output logic                      stream_bit_of,
  output logic                      stream_pixel_of,
  output logic                      frame_done,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  localparam int IW = BUFFER_BITS + 1;

  state_e                    state_q, state_d;
  logic [PAT_W-1:0]          pat_q;
  logic [4:0]                bit_q;
  logic [BUFFER_BITS-1:0]    idx_q, max_q;
  logic                      rgbw_q, w32_q, rearm_q;
  logic [FRAME_CNT_BITS-1:0] fc_q;

  logic                   tx, rs, start, leave_tx, at_end, timer_done, unused_reg_max;
  logic [BUFFER_BITS-1:0] eq_idx;
  logic [IW-1:0]          next_idx;

  assign unused_reg_max = &{1'b0, reg_max};

  assign tx = (state_q == ENUM_STATE_TRANSMIT);
  assign rs = (state_q == ENUM_STATE_RESET);

  // In word mode a pixel covers bytes idx..idx+3, so its last byte is the
  // one compared against the limit.
  assign eq_idx   = w32_q ? (idx_q | BUFFER_BITS'(3)) : idx_q;
  assign next_idx = {1'b0, idx_q} + (w32_q ? IW'(4) : IW'(1));
  // The next pixel would fall outside the buffer: this one must be the last.
  assign at_end   = next_idx > IW'(BUFFER_END);

  assign stream_output     = tx;
  assign stream_reset      = rs;
  assign stream_pattern_of = tx && (pat_q == PAT_W'(PATTERN_STEPS - 1));
  assign stream_bit_of     = stream_pattern_of && (bit_q == last_bit(rgbw_q));
  assign stream_pixel_of   = tx && ((eq_idx == max_q) || at_end);

  // A pixel in flight is always completed; run=0 only ends the frame early.
  assign leave_tx = stream_bit_of && (stream_pixel_of || !reg_ctrl_run);
  assign start    = (state_d == ENUM_STATE_TRANSMIT) && !tx;

  assign state             = state_q;
  assign pixel_index       = idx_q;
  assign pixel_bit_index   = bit_q;
  assign bit_pattern_index = pat_q;
  assign frame_done        = timer_done;
  assign frame_count       = fc_q;

  anton_neopixel_stream_seq_reset_timer #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_timer (
    .clk7mhz(clk7mhz),
    .rstn   (rstn),
    .load   (reg_ctrl_init || !rs),
    .count  (rs),
    .done   (timer_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENUM_STATE_IDLE:     if (reg_ctrl_run && !rearm_q) state_d = ENUM_STATE_TRANSMIT;
      ENUM_STATE_TRANSMIT: if (leave_tx) state_d = ENUM_STATE_RESET;
      ENUM_STATE_RESET: begin
        if (timer_done) begin
          state_d = (reg_ctrl_run && reg_ctrl_loop) ? ENUM_STATE_TRANSMIT : ENUM_STATE_IDLE;
        end
      end
      default:             state_d = ENUM_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= ENUM_STATE_IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      rgbw_q  <= 1'b0;
      w32_q   <= 1'b0;
      rearm_q <= 1'b0;
      fc_q    <= '0;
    end else if (reg_ctrl_init) begin
      state_q <= ENUM_STATE_IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      rgbw_q  <= 1'b0;
      w32_q   <= 1'b0;
      rearm_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;

      if (start) begin
        max_q  <= reg_ctrl_limit ? reg_max[BUFFER_BITS-1:0] : BUFFER_BITS'(BUFFER_END);
        rgbw_q <= reg_ctrl_rgbw;
        w32_q  <= reg_ctrl_32bit;
      end

      if (leave_tx) begin
        pat_q <= '0;
        bit_q <= '0;
        idx_q <= '0;
      end else if (tx) begin
        pat_q <= stream_pattern_of ? '0 : pat_q + 1'b1;
        if (stream_pattern_of) bit_q <= stream_bit_of ? '0 : bit_q + 5'd1;
        if (stream_bit_of) idx_q <= next_idx[BUFFER_BITS-1:0];
      end

      // A non-looping frame that ends with run still high must see run
      // drop before another frame may start.
      if (!tx && !rs && !reg_ctrl_run) begin
        rearm_q <= 1'b0;
      end else if (timer_done && reg_ctrl_run && !reg_ctrl_loop) begin
        rearm_q <= 1'b1;
      end

      if (timer_done) fc_q <= fc_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_stream_seq.sv
// Bench for anton_neopixel_stream_seq (BUFFER_END=7, PATTERN_STEPS=8, RESET_CYCLES=10).
// A frame-level model derives every output from the phase and the cycle
// offset within that phase; directed scenarios pin frame lengths, followed
// by a randomized control phase.
module tb_anton_neopixel_stream_seq;

  localparam int BE = 7;
  localparam int PS = 8;
  localparam int RC = 10;

  logic        clk7mhz = 1'b0;
  logic        rstn = 1'b0;
  logic        reg_ctrl_init = 1'b0, reg_ctrl_run = 1'b0, reg_ctrl_limit = 1'b0;
  logic        reg_ctrl_32bit = 1'b0, reg_ctrl_rgbw = 1'b0, reg_ctrl_loop = 1'b0;
  logic [12:0] reg_max = '0;
  logic [1:0]  state;
  logic [2:0]  pixel_index;
  logic [4:0]  pixel_bit_index;
  logic [2:0]  bit_pattern_index;
  logic        stream_output, stream_reset, stream_pattern_of, stream_bit_of;
  logic        stream_pixel_of, frame_done;
  logic [15:0] frame_count;

  anton_neopixel_stream_seq #(
    .BUFFER_END(BE), .PATTERN_STEPS(PS), .RESET_CYCLES(RC), .FRAME_CNT_BITS(16)
  ) dut (
    .clk7mhz(clk7mhz), .rstn(rstn),
    .reg_ctrl_init(reg_ctrl_init), .reg_ctrl_run(reg_ctrl_run),
    .reg_ctrl_limit(reg_ctrl_limit), .reg_ctrl_32bit(reg_ctrl_32bit),
    .reg_ctrl_rgbw(reg_ctrl_rgbw), .reg_ctrl_loop(reg_ctrl_loop),
    .reg_max(reg_max), .state(state), .pixel_index(pixel_index),
    .pixel_bit_index(pixel_bit_index), .bit_pattern_index(bit_pattern_index),
    .stream_output(stream_output), .stream_reset(stream_reset),
    .stream_pattern_of(stream_pattern_of), .stream_bit_of(stream_bit_of),
    .stream_pixel_of(stream_pixel_of), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk7mhz = ~clk7mhz;

  int tests = 0;
  int fails = 0;

  // ---------------- frame-level model ----------------
  // mode: 0 idle, 1 transmit, 2 latch period; t = cycles spent in the phase.
  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] t;
    logic [3:0]  maxi;
    logic [5:0]  bpp;
    logic        w32;
    logic        rearm;
    logic [15:0] fc;
  } mstate_t;

  mstate_t m;

  function automatic bit m_last(mstate_t s, int k);
    int step = s.w32 ? 4 : 1;
    int idx  = k * step;
    int eq   = s.w32 ? (idx | 3) : idx;
    return (eq == int'(s.maxi)) || (idx + step > BE);
  endfunction

  function automatic mstate_t m_latch(mstate_t s, bit limit, bit rgbw, bit w32, logic [12:0] rmax);
    mstate_t n = s;
    n.maxi = limit ? {1'b0, rmax[2:0]} : 4'(BE);
    n.bpp  = rgbw ? 6'd32 : 6'd24;
    n.w32  = w32;
    n.mode = 2'd1;
    n.t    = '0;
    return n;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit run, bit loop, bit limit,
                                         bit rgbw, bit w32, logic [12:0] rmax);
    mstate_t n = s;
    int per = int'(s.bpp) * PS;
    int t = int'(s.t);
    case (s.mode)
      2'd0: begin
        if (!run) n.rearm = 1'b0;
        else if (!s.rearm) n = m_latch(s, limit, rgbw, w32, rmax);
      end
      2'd1: begin
        if ((t % per) == per - 1 && (m_last(s, t / per) || !run)) begin
          n.mode = 2'd2;
          n.t = '0;
        end else n.t = 16'(t + 1);
      end
      default: begin
        if (t == RC - 1) begin
          n.fc = s.fc + 16'd1;
          if (run && loop) n = m_latch(n, limit, rgbw, w32, rmax);
          else begin
            n.mode = 2'd0;
            n.t = '0;
            n.rearm = run;
          end
        end else n.t = 16'(t + 1);
      end
    endcase
    return n;
  endfunction

  function automatic logic [34:0] model_out(mstate_t s);
    logic [2:0] pix = '0;
    logic [4:0] pbi = '0;
    logic [2:0] bpi = '0;
    logic so = 1'b0, sr = 1'b0, pof = 1'b0, bof = 1'b0, pxo = 1'b0, fd = 1'b0;
    int per, t, k, r;
    t = int'(s.t);
    if (s.mode == 2'd1) begin
      per = int'(s.bpp) * PS;
      k   = t / per;
      r   = t % per;
      so  = 1'b1;
      pix = 3'(k * (s.w32 ? 4 : 1));
      pbi = 5'(r / PS);
      bpi = 3'(r % PS);
      pof = (r % PS) == PS - 1;
      bof = r == per - 1;
      pxo = m_last(s, k);
    end else if (s.mode == 2'd2) begin
      sr = 1'b1;
      fd = (t == RC - 1);
    end
    return {s.mode, pix, pbi, bpi, so, sr, pof, bof, pxo, fd, s.fc};
  endfunction

  always @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) m <= '0;
    else if (reg_ctrl_init) m <= '0;
    else m <= model_next(m, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_limit,
                         reg_ctrl_rgbw, reg_ctrl_32bit, reg_max);
  end

  // ---------------- compare process + frame monitors ----------------
  logic [34:0] got_v, exp_v;
  int cyc = 0, prev_state = 0, since = 0, tx_cur = 0, rs_cur = 0;
  int last_tx_len = 0, last_rs_len = 0, done_at = 0, done_cnt = 0;
  int last_done_cyc = 0, done_gap = 0, max_pbi = 0, pof_idx = -1;

  always @(negedge clk7mhz) begin
    got_v = {state, pixel_index, pixel_bit_index, bit_pattern_index, stream_output,
             stream_reset, stream_pattern_of, stream_bit_of, stream_pixel_of,
             frame_done, frame_count};
    exp_v = model_out(m);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_compare @%0t: got %h expected %h", $time, got_v, exp_v);
    end
    cyc++;
    if (state == 2'd1 && prev_state != 1) begin since = 1; tx_cur = 1; end
    else begin
      if (since != 0) since++;
      if (state == 2'd1) tx_cur++;
    end
    if (prev_state == 1 && state != 2'd1) last_tx_len = tx_cur;
    if (state == 2'd2) rs_cur++;
    if (prev_state == 2 && state != 2'd2) begin last_rs_len = rs_cur; rs_cur = 0; end
    if (state != 2'd2 && prev_state != 2) rs_cur = 0;
    if (frame_done) begin
      done_at = since;
      done_cnt++;
      done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
    if (state == 2'd1 && int'(pixel_bit_index) > max_pbi) max_pbi = int'(pixel_bit_index);
    if (stream_pixel_of && pof_idx < 0) pof_idx = int'(pixel_index);
    prev_state = int'(state);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk7mhz);
    #1;
  endtask

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin tick(); c++; end
    check("wait_frame_done", done_cnt >= target, 1);
  endtask

  task automatic wait_state(input int s, input int budget);
    int c = 0;
    while (int'(state) != s && c < budget) begin tick(); c++; end
    check("wait_state", int'(state), s);
  endtask

  task automatic set_cfg(input bit limit, input bit rgbw, input bit w32, input bit loop,
                         input int rmax);
    reg_ctrl_limit = limit;
    reg_ctrl_rgbw  = rgbw;
    reg_ctrl_32bit = w32;
    reg_ctrl_loop  = loop;
    reg_max        = 13'(rmax);
  endtask

  initial begin
    int base;
    int c;
    repeat (3) tick();
    check("reset_state", int'(state), 0);
    check("reset_frame_count", int'(frame_count), 0);
    rstn = 1'b1;
    tick();

    // Basic RGB frame, two pixels.
    set_cfg(1, 0, 0, 0, 1);
    base = done_cnt;
    reg_ctrl_run = 1'b1;
    wait_done(base + 1, 1000);
    tick();
    check("basic_tx_len", last_tx_len, 384);
    check("basic_done_at", done_at, 394);
    check("basic_reset_len", last_rs_len, 10);
    check("basic_frame_count", int'(frame_count), 1);
    repeat (20) tick();
    check("basic_no_rearm", int'(state), 0);
    reg_ctrl_run = 1'b0;
    tick();

    // RGBW with word addressing.
    set_cfg(1, 1, 1, 0, 7);
    max_pbi = 0;
    pof_idx = -1;
    base = done_cnt;
    reg_ctrl_run = 1'b1;
    wait_done(base + 1, 1000);
    tick();
    reg_ctrl_run = 1'b0;
    check("rgbw_tx_len", last_tx_len, 512);
    check("rgbw_max_bit", max_pbi, 31);
    check("rgbw_pixel_of_idx", pof_idx, 4);
    check("rgbw_frame_count", int'(frame_count), 2);
    tick();

    // Loop mode over the whole buffer.
    set_cfg(0, 0, 0, 1, 0);
    base = done_cnt;
    reg_ctrl_run = 1'b1;
    wait_done(base + 3, 6000);
    check("loop_gap", done_gap, 1546);
    tick();
    check("loop_frame_count", int'(frame_count), 5);
    reg_ctrl_run = 1'b0;
    wait_state(0, 2000);

    // Mid-frame limit write applies to the next frame only.
    set_cfg(1, 0, 0, 1, 1);
    base = done_cnt;
    reg_ctrl_run = 1'b1;
    repeat (100) tick();
    reg_max = 13'd5;
    wait_done(base + 1, 1000);
    check("midwrite_first_tx_len", last_tx_len, 384);
    wait_done(base + 2, 2000);
    check("midwrite_second_tx_len", last_tx_len, 1152);
    reg_ctrl_run = 1'b0;
    wait_state(0, 3000);

    // Graceful stop inside pixel 2.
    set_cfg(0, 0, 0, 0, 0);
    reg_ctrl_run = 1'b1;
    c = 0;
    while (!(pixel_index == 3'd2 && pixel_bit_index == 5'd5) && c < 2000) begin tick(); c++; end
    check("graceful_reached", c < 2000, 1);
    reg_ctrl_run = 1'b0;
    wait_state(2, 1000);
    check("graceful_tx_len", last_tx_len, 576);
    wait_state(0, 100);
    check("graceful_reset_len", last_rs_len, 10);

    // Soft clear mid-transmit.
    reg_ctrl_run = 1'b1;
    repeat (50) tick();
    reg_ctrl_init = 1'b1;
    tick();
    check("init_state", int'(state), 0);
    check("init_output", stream_output, 0);
    check("init_frame_count", int'(frame_count), 0);
    reg_ctrl_init = 1'b0;
    base = done_cnt;
    wait_done(base + 1, 2000);
    tick();
    check("after_init_frame_count", int'(frame_count), 1);

    // Asynchronous reset inside the latch period.
    reg_ctrl_run = 1'b0;
    tick();
    reg_ctrl_run = 1'b1;
    wait_state(2, 2000);
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    check("rstn_state", int'(state), 0);
    check("rstn_stream_reset", stream_reset, 0);
    check("rstn_frame_count", int'(frame_count), 0);
    tick();
    rstn = 1'b1;
    tick();

    // Randomized control traffic; the per-cycle model check covers it.
    for (int i = 0; i < 8000; i++) begin
      if (i % 500 == 0)
        set_cfg($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 299) == 0) reg_ctrl_run = ~reg_ctrl_run;
      if ($urandom_range(0, 49) == 0) reg_max = 13'($urandom_range(0, 8191));
      reg_ctrl_init = ($urandom_range(0, 1999) == 0);
      tick();
    end
    reg_ctrl_init = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
